// File: rtl/x2050pswfld.sv
// x2050pswfld: parametrised PSW field register with shadow copy, ROS ops and external set
module x2050pswfld #(
  parameter int WIDTH = 4,
  parameter int FIELD_POS = 12,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [5:0] SS_LOAD_A = 6'd55,
  parameter logic [5:0] SS_LOAD_B = 6'd56,
  parameter logic [5:0] SS_OR = 6'd57,
  parameter logic [5:0] SS_AND = 6'd58,
  parameter logic [5:0] SS_SWAP = 6'd59,
  parameter logic [5:0] SS_SAVE = 6'd60,
  parameter logic [5:0] SS_RESTORE = 6'd61
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ros_advance,
  input  logic [5:0]       i_ss,
  input  logic [31:0]      i_t_reg,
  input  logic [WIDTH-1:0] i_set,
  output logic [WIDTH-1:0] o_field,
  output logic [WIDTH-1:0] o_shadow,
  output logic             o_changed
);
  logic [WIDTH-1:0] field_q, field_d, shadow_q, shadow_d, slice, ros_r;
  logic ld, orm, anm, swp, sav, rst;
  assign slice = i_t_reg[31-FIELD_POS -: WIDTH];
  // Decode the ROS op in fixed priority and form next field/shadow; i_set is ORed in every clock
  always_comb begin
    ld = i_ros_advance && (i_ss == SS_LOAD_A || i_ss == SS_LOAD_B);
    orm = i_ros_advance && i_ss == SS_OR;
    anm = i_ros_advance && i_ss == SS_AND;
    swp = i_ros_advance && i_ss == SS_SWAP;
    sav = i_ros_advance && i_ss == SS_SAVE;
    rst = i_ros_advance && i_ss == SS_RESTORE;
    ros_r = ld ? slice : orm ? (field_q | slice) : anm ? (field_q & slice) : swp ? slice : sav ? field_q : rst ? shadow_q : field_q;
    shadow_d = (!ld && !orm && !anm && (swp || sav)) ? field_q : shadow_q;
    field_d = ros_r | i_set;
  end
  // Register field, shadow and the change flag; reset wins over any concurrent op
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      field_q <= RESET_VALUE;
      shadow_q <= RESET_VALUE;
      o_changed <= 1'b0;
    end else begin
      field_q <= field_d;
      shadow_q <= shadow_d;
      o_changed <= field_d != field_q;
    end
  end
  assign o_field = field_q;
  assign o_shadow = shadow_q;
endmodule

// File: tb/tb_x2050pswfld.sv
// tb_x2050pswfld: directed plus random checks of two field instances against a behavioural model
module tb_x2050pswfld;
  logic clk = 0, rst = 1, adv = 0;
  logic [5:0] ss = 0;
  logic [31:0] t = 0;
  logic [3:0] set4 = 0, f4, sh4;
  logic [7:0] set8 = 0, f8, sh8;
  logic ch4, ch8;
  int checks = 0, errors = 0;
  int m4f, m4s, m8f, m8s;
  bit m4c, m8c;
  always #5 clk = ~clk;
  x2050pswfld dut4 (.i_clk(clk), .i_reset(rst), .i_ros_advance(adv), .i_ss(ss), .i_t_reg(t),
    .i_set(set4), .o_field(f4), .o_shadow(sh4), .o_changed(ch4));
  x2050pswfld #(.WIDTH(8), .FIELD_POS(0), .RESET_VALUE(8'hFF)) dut8 (.i_clk(clk), .i_reset(rst),
    .i_ros_advance(adv), .i_ss(ss), .i_t_reg(t), .i_set(set8), .o_field(f8), .o_shadow(sh8), .o_changed(ch8));

  task automatic model(input int w, input int pos, input int rv, input int set, inout int f, inout int sh, inout bit ch);
    int mask, s, r, nsh, nf;
    mask = (1 << w) - 1;
    s = int'(t >> (32 - pos - w)) & mask;
    if (rst) begin
      f = rv; sh = rv; ch = 0;
      return;
    end
    r = f; nsh = sh;
    if (adv) begin
      if (ss == 55 || ss == 56) r = s;
      else if (ss == 57) r = f | s;
      else if (ss == 58) r = f & s;
      else if (ss == 59) begin nsh = f; r = s; end
      else if (ss == 60) nsh = f;
      else if (ss == 61) r = sh;
    end
    nf = (r | set) & mask;
    ch = nf != f;
    f = nf; sh = nsh;
  endtask

  task automatic cmp(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit a, input int code, input logic [31:0] tv, input logic [3:0] s4, input logic [7:0] s8);
    rst = r; adv = a; ss = 6'(code); t = tv; set4 = s4; set8 = s8;
    model(4, 12, 0, int'(s4), m4f, m4s, m4c);
    model(8, 0, 255, int'(s8), m8f, m8s, m8c);
    @(posedge clk); #1;
    cmp("field4", int'(f4), m4f);
    cmp("shadow4", int'(sh4), m4s);
    cmp("changed4", int'(ch4), int'(m4c));
    cmp("field8", int'(f8), m8f);
    cmp("shadow8", int'(sh8), m8s);
    cmp("changed8", int'(ch8), int'(m8c));
    @(negedge clk);
  endtask

  initial begin
    m4f = 0; m4s = 0; m8f = 0; m8s = 0; m4c = 0; m8c = 0;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0);
    cmp("reset_field8_const", int'(f8), 'hFF);
    cyc(0, 1, 55, 32'h000F_0000, 0, 0);
    cmp("load_F", int'(f4), 'hF);
    cyc(0, 1, 56, 32'h000F_0000, 0, 0);
    cmp("reload_nochange", int'(ch4), 0);
    cyc(0, 1, 55, 32'h000A_0000, 0, 0);
    cyc(0, 1, 57, 32'h0005_0000, 0, 0);
    cmp("or_merge", int'(f4), 'hF);
    cyc(0, 1, 58, 32'h0003_0000, 0, 0);
    cmp("and_merge", int'(f4), 'h3);
    cyc(0, 0, 57, 32'h000C_0000, 0, 0);
    cyc(0, 0, 55, 32'h000C_0000, 0, 0);
    cmp("noadv_hold", int'(f4), 'h3);
    cyc(0, 1, 55, 32'h0006_0000, 0, 0);
    cyc(0, 1, 59, 32'h0009_0000, 0, 0);
    cmp("swap_field", int'(f4), 'h9);
    cmp("swap_shadow", int'(sh4), 'h6);
    cyc(0, 1, 61, 0, 0, 0);
    cmp("restore", int'(f4), 'h6);
    cyc(0, 1, 60, 0, 0, 0);
    cmp("save_nochange", int'(ch4), 0);
    cyc(0, 1, 55, 0, 0, 0);
    cyc(0, 1, 61, 0, 0, 0);
    cmp("save_load_restore", int'(f4), 'h6);
    cyc(0, 1, 55, 0, 0, 0);
    cyc(0, 0, 0, 0, 4'b0100, 0);
    cmp("set_noadv", int'(f4), 'h4);
    cyc(0, 1, 58, 0, 4'b0001, 0);
    cmp("and_with_set", int'(f4), 'h1);
    cyc(0, 1, 59, 32'h0008_0000, 4'b0110, 8'h01);
    cmp("swap_set_shadow", int'(sh4), 'h1);
    cmp("swap_set_field", int'(f4), 'hE);
    cyc(1, 1, 59, 32'h000F_0000, 4'hF, 8'hFF);
    cmp("reset_swap_shadow", int'(sh4), 0);
    cyc(0, 1, 55, 32'hA512_3456, 0, 0);
    cmp("alt_load", int'(f8), 'hA5);
    cyc(0, 0, 0, 32'hA5ED_CBA9, 0, 0);
    cyc(0, 1, 56, 32'hA5ED_CBA9, 0, 0);
    cmp("alt_outside_bits", int'(f8), 'hA5);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, $urandom_range(52, 63), $urandom,
          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
